// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and the bus side: show-ahead read port,
// sticky overrun/BREAK flags. Optional level/flag interrupt: UART_RX_FIFO_THRESH_IRQ_EN.
module uart_rx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH = 16
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
  , parameter int THRESH = DEPTH / 2
`endif
  , localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    uart_rx_valid,
  input  logic                    uart_rx_break,
  input  logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [PAYLOAD_BITS-1:0] rd_data,
  input  logic                    flush,
  input  logic                    clr_flags,
  output logic [ADDR_W:0]         level,
  output logic                    overrun,
  output logic                    break_det
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
  , output logic                  rx_irq
`endif
);

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];

  logic [ADDR_W:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W:0] level_reg, level_next;
  logic            overrun_reg, overrun_next;
  logic            break_det_reg, break_det_next;

  logic empty, full, push, pop, drop, brk_evt;

  // The extra MSB on each pointer distinguishes full from empty when indices match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]) &&
                   (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]);
  assign pop     = !empty && rd_ready;
  assign push    = uart_rx_valid && !uart_rx_break && (!full || pop);
  assign drop    = uart_rx_valid && !uart_rx_break && full && !pop;
  assign brk_evt = uart_rx_valid && uart_rx_break;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    level_next     = level_reg;
    overrun_next   = overrun_reg;
    break_det_next = break_det_reg;

    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + (ADDR_W+1)'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + (ADDR_W+1)'(1);
      if (push && !pop)      level_next = level_reg + (ADDR_W+1)'(1);
      else if (pop && !push) level_next = level_reg - (ADDR_W+1)'(1);
    end

    // A set event in the same cycle as clr_flags leaves the flag set.
    if (drop)           overrun_next = 1'b1;
    else if (clr_flags) overrun_next = 1'b0;

    if (brk_evt)        break_det_next = 1'b1;
    else if (clr_flags) break_det_next = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      overrun_reg   <= 1'b0;
      break_det_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      level_reg     <= level_next;
      overrun_reg   <= overrun_next;
      break_det_reg <= break_det_next;
    end
  end

  // Storage holds no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_reg[ADDR_W-1:0]] <= uart_rx_data;
  end

  assign rd_valid  = !empty;
  assign rd_data   = empty ? '0 : mem[rd_ptr_reg[ADDR_W-1:0]];
  assign level     = level_reg;
  assign overrun   = overrun_reg;
  assign break_det = break_det_reg;

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
  logic rx_irq_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_irq_reg <= 1'b0;
    else       rx_irq_reg <= (level_reg >= (ADDR_W+1)'(THRESH)) || overrun_reg || break_det_reg;
  end

  assign rx_irq = rx_irq_reg;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic
// against a queue-based model of the FIFO and its sticky flags.
module tb_uart_rx_fifo;
  localparam int DEPTH  = 16;
  localparam int THRESH = DEPTH / 2;

  logic       clk;
  logic       reset;
  logic       uart_rx_valid;
  logic       uart_rx_break;
  logic [7:0] uart_rx_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       flush;
  logic       clr_flags;
  logic [4:0] level;
  logic       overrun;
  logic       break_det;
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
  logic       rx_irq;
`endif

  uart_rx_fifo #(.PAYLOAD_BITS(8), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_break(uart_rx_break),
    .uart_rx_data(uart_rx_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_data(rd_data),
    .flush(flush),
    .clr_flags(clr_flags),
    .level(level),
    .overrun(overrun),
    .break_det(break_det)
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    , .rx_irq(rx_irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of stored bytes plus the two sticky flags.
  logic [7:0] q[$];
  bit m_ov, m_brk, m_irq;

  function automatic logic [7:0] exp_data();
    return (q.size() > 0) ? q[0] : 8'h00;
  endfunction

  // Applies one clock cycle of inputs and advances the model; returns 1 ns after the edge.
  task automatic drive(input bit v, input bit b, input logic [7:0] d,
                       input bit rdy, input bit fl, input bit clr);
    int n;
    bit p, dropped;
    uart_rx_valid = v; uart_rx_break = b; uart_rx_data = d;
    rd_ready = rdy; flush = fl; clr_flags = clr;
    n = q.size();
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    m_irq = (n >= THRESH) || m_ov || m_brk;
`endif
    p = (n > 0) && rdy;
    dropped = v && !b && (n == DEPTH) && !p;
    if (fl) q.delete();
    else begin
      if (p) void'(q.pop_front());
      if (v && !b && !dropped) q.push_back(d);
    end
    m_ov  = dropped ? 1'b1 : (clr ? 1'b0 : m_ov);
    m_brk = (v && b) ? 1'b1 : (clr ? 1'b0 : m_brk);
    @(posedge clk);
    #1;
    uart_rx_valid = 0; uart_rx_break = 0; uart_rx_data = 0;
    rd_ready = 0; flush = 0; clr_flags = 0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (level !== 5'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00 ||
        overrun !== 1'b0 || break_det !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got lvl=%0d v=%b d=%h ov=%b brk=%b want all zero",
               level, rd_valid, rd_data, overrun, break_det);
    end
    $display("reset: level=%0d rd_valid=%b", level, rd_valid);
  endtask

  task automatic test_basic();
    logic [7:0] want;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 8'h41 + 8'(i), 0, 0, 0);
      for (int k = 0; k < 9; k++) drive(0, 0, 0, 0, 0, 0);
    end
    n_checks++;
    if (level !== 5'd3 || rd_valid !== 1'b1 || rd_data !== 8'h41) begin
      n_fail++;
      $display("FAIL basic_fill: got lvl=%0d v=%b d=%h want 3 1 41", level, rd_valid, rd_data);
    end
    for (int i = 0; i < 3; i++) begin
      want = 8'h41 + 8'(i);
      n_checks++;
      if (rd_data !== want) begin
        n_fail++;
        $display("FAIL basic_read%0d: got %h want %h", i, rd_data, want);
      end
      $display("basic read %0d: data=%h", i, rd_data);
      drive(0, 0, 0, 1, 0, 0);
    end
    n_checks++;
    if (level !== 5'd0 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_empty: got lvl=%0d v=%b want 0 0", level, rd_valid);
    end
  endtask

  task automatic test_overrun();
    drive(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < DEPTH; i++) drive(1, 0, 8'(i), 0, 0, 0);
    n_checks++;
    if (overrun !== 1'b0 || level !== 5'd16) begin
      n_fail++;
      $display("FAIL ovr_full: got ov=%b lvl=%0d want 0 16", overrun, level);
    end
    drive(1, 0, 8'hAA, 0, 0, 0);
    n_checks++;
    if (overrun !== 1'b1 || level !== 5'd16) begin
      n_fail++;
      $display("FAIL ovr_drop: got ov=%b lvl=%0d want 1 16", overrun, level);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (rd_data !== 8'(i) || rd_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL ovr_drain%0d: got %h v=%b want %h 1", i, rd_data, rd_valid, 8'(i));
      end
      drive(0, 0, 0, 1, 0, 0);
    end
    n_checks++;
    if (rd_valid !== 1'b0 || level !== 5'd0) begin
      n_fail++;
      $display("FAIL ovr_after: got v=%b lvl=%0d want 0 0 (0xAA must not be stored)", rd_valid, level);
    end
    $display("overrun: flag=%b level=%0d", overrun, level);
  endtask

  task automatic test_full_push_pop();
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) drive(1, 0, 8'h10 + 8'(i), 0, 0, 0);
    drive(1, 0, 8'h55, 1, 0, 0);
    n_checks++;
    if (level !== 5'd16 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL fpp_level: got lvl=%0d ov=%b want 16 0", level, overrun);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (rd_data !== exp_data()) begin
        n_fail++;
        $display("FAIL fpp_drain%0d: got %h want %h", i, rd_data, exp_data());
      end
      if (i == DEPTH - 1) begin
        n_checks++;
        if (rd_data !== 8'h55) begin
          n_fail++;
          $display("FAIL fpp_last: got %h want 55", rd_data);
        end
      end
      drive(0, 0, 0, 1, 0, 0);
    end
    $display("full push+pop: level=%0d", level);
  endtask

  task automatic test_break();
    drive(1, 0, 8'h77, 0, 0, 0);
    drive(1, 1, 8'h00, 0, 0, 0);
    n_checks++;
    if (break_det !== 1'b1 || level !== 5'd1 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL brk_set: got brk=%b lvl=%0d ov=%b want 1 1 0", break_det, level, overrun);
    end
    drive(0, 0, 0, 0, 0, 1);
    n_checks++;
    if (break_det !== 1'b0) begin
      n_fail++;
      $display("FAIL brk_clr: got %b want 0", break_det);
    end
    drive(1, 1, 8'h00, 0, 0, 1);
    n_checks++;
    if (break_det !== 1'b1) begin
      n_fail++;
      $display("FAIL brk_clr_race: got %b want 1", break_det);
    end
    drive(0, 0, 0, 1, 0, 1);
    $display("break: break_det=%b level=%0d", break_det, level);
  endtask

  task automatic test_wrap_flush();
    for (int i = 0; i < 40; i++) begin
      drive(1, 0, 8'(8'h80 + i), ($urandom_range(0, 2) != 0), 0, 0);
      n_checks++;
      if (rd_data !== exp_data() || level !== 5'(q.size())) begin
        n_fail++;
        $display("FAIL wrap%0d: got d=%h lvl=%0d want %h %0d", i, rd_data, level, exp_data(), q.size());
      end
    end
    while (q.size() > 2) begin
      n_checks++;
      if (rd_data !== exp_data()) begin
        n_fail++;
        $display("FAIL wrap_drain: got %h want %h", rd_data, exp_data());
      end
      drive(0, 0, 0, 1, 0, 0);
    end
    drive(1, 0, 8'hEE, 0, 1, 0);
    n_checks++;
    if (level !== 5'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL flush: got lvl=%0d v=%b d=%h want 0 0 00", level, rd_valid, rd_data);
    end
    $display("wrap+flush: level=%0d", level);
  endtask

  task automatic test_random();
    bit v, b;
    for (int c = 0; c < 500; c++) begin
      v = ($urandom_range(0, 2) == 0);
      b = ($urandom_range(0, 15) == 0);
      drive(v, b, 8'($urandom), $urandom_range(0, 1) == 1,
            $urandom_range(0, 79) == 0, $urandom_range(0, 31) == 0);
      n_checks++;
      if (level !== 5'(q.size()) || rd_valid !== (q.size() > 0) || rd_data !== exp_data() ||
          overrun !== m_ov || break_det !== m_brk) begin
        n_fail++;
        $display("FAIL rand%0d: got lvl=%0d v=%b d=%h ov=%b brk=%b want %0d %b %h %b %b",
                 c, level, rd_valid, rd_data, overrun, break_det,
                 q.size(), q.size() > 0, exp_data(), m_ov, m_brk);
      end
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
      n_checks++;
      if (rx_irq !== m_irq) begin
        n_fail++;
        $display("FAIL rand_irq%0d: got %b want %b", c, rx_irq, m_irq);
      end
`endif
    end
    $display("random: final level=%0d", level);
  endtask

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
  task automatic test_irq();
    drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < THRESH; i++) drive(1, 0, 8'(i), 0, 0, 0);
    n_checks++;
    if (rx_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_lag: got %b want 0", rx_irq);
    end
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (rx_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_set: got %b want 1", rx_irq);
    end
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (rx_irq !== 1'b0 || level !== 5'(THRESH - 1)) begin
      n_fail++;
      $display("FAIL irq_clr: got irq=%b lvl=%0d want 0 %0d", rx_irq, level, THRESH - 1);
    end
    $display("irq: rx_irq=%b level=%0d", rx_irq, level);
  endtask
`endif

  task automatic test_async_reset();
    drive(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) drive(1, 0, 8'hC0 + 8'(i), 0, 0, 0);
    drive(1, 1, 8'h00, 0, 0, 0);
    n_checks++;
    if (level !== 5'd5 || break_det !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: got lvl=%0d brk=%b want 5 1", level, break_det);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (level !== 5'd0 || rd_valid !== 1'b0 || break_det !== 1'b0 ||
        overrun !== 1'b0 || rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL arst: got lvl=%0d v=%b brk=%b ov=%b d=%h want all zero",
               level, rd_valid, break_det, overrun, rd_data);
    end
    q.delete(); m_ov = 0; m_brk = 0; m_irq = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    $display("async reset: level=%0d", level);
  endtask

  initial begin
    reset = 1'b1;
    uart_rx_valid = 0; uart_rx_break = 0; uart_rx_data = 0;
    rd_ready = 0; flush = 0; clr_flags = 0;
    m_ov = 0; m_brk = 0; m_irq = 0;
    #1;
    test_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    test_basic();
    test_overrun();
    test_full_push_pop();
    test_break();
    test_wrap_flush();
    test_random();
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    test_irq();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
